// File: rtl/sha256_const_rom_if.sv
// sha256_const_rom_if: hash-core request/valid handshake plus the shared EEPROM bus.
// CONST_ROM_SHA224_EN adds the h224 table-variant select.
interface sha256_const_rom_if #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 13
);
  logic              req;
  logic              sel;
  logic [6:0]        idx;
  logic              burst;
  logic              ready;
  logic              valid;
  logic [8*LANES-1:0] data;
  logic              last;
  logic              err;
  logic [ADDR_W-1:0] a;
  logic              ce_n;
  logic              oe_n;
  logic [8*LANES-1:0] io;
`ifdef CONST_ROM_SHA224_EN
  logic              h224;
  modport master (output req, sel, idx, burst, h224, io,
                  input  ready, valid, data, last, err, a, ce_n, oe_n);
  modport slave  (input  req, sel, idx, burst, h224, io,
                  output ready, valid, data, last, err, a, ce_n, oe_n);
`else
  modport master (output req, sel, idx, burst, io,
                  input  ready, valid, data, last, err, a, ce_n, oe_n);
  modport slave  (input  req, sel, idx, burst, io,
                  output ready, valid, data, last, err, a, ce_n, oe_n);
`endif
endinterface

// File: rtl/sha256_const_rom.sv
// sha256_const_rom: fetches SHA-256 H/K constants from parallel byte-wide EEPROMs.
// CONST_ROM_SHA224_EN adds the SHA-224 IV as an alternate H table at H_BASE+72.
module sha256_const_rom #(
  parameter int LANES       = 4,
  parameter int ADDR_W      = 13,
  parameter int WAIT_CYCLES = 2,
  parameter int H_BASE      = 0,
  parameter int K_BASE      = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  sha256_const_rom_if.slave bus
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t             r_state, w_next;
  logic               r_sel, r_burst, r_h224;
  logic [6:0]         r_ptr;
  logic [3:0]         r_cnt;
  logic [8*LANES-1:0] r_data;
  logic               r_valid, r_last, r_err;
  logic               w_accept, w_legal, w_term, w_end, w_h224;
  int                 w_base;
  logic [ADDR_W-1:0]  w_addr;
`ifdef CONST_ROM_SHA224_EN
  assign w_h224 = bus.h224;
`else
  assign w_h224 = 1'b0;
`endif
  assign w_accept = bus.req && r_state == IDLE;
  assign w_legal  = bus.idx <= (bus.sel ? 7'd63 : 7'd7);
  assign w_term   = r_cnt == 4'(WAIT_CYCLES);
  assign w_end    = r_ptr == (r_sel ? 7'd63 : 7'd7);
  assign w_base   = r_sel ? K_BASE : r_h224 ? H_BASE + 72 : H_BASE;
  assign w_addr   = ADDR_W'(w_base + 32'(r_ptr));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_accept && w_legal ? ACCESS : IDLE)
                             : (w_term && !(r_burst && !w_end) ? IDLE : ACCESS);
  always_comb begin
    bus.ready = r_state == IDLE;
    bus.ce_n  = r_state != ACCESS;
    bus.oe_n  = r_state != ACCESS;
    bus.a     = r_state == ACCESS ? w_addr : '0;
  end
  // strobes default low every cycle; the capture edge also steps the burst pointer
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sel   <= 1'b0;
      r_burst <= 1'b0;
      r_h224  <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_sel   <= bus.sel;
        r_burst <= bus.burst;
        r_h224  <= w_h224;
        r_ptr   <= bus.idx;
        r_cnt   <= '0;
      end else if (r_state == ACCESS) begin
        r_cnt <= w_term ? 4'd0 : r_cnt + 4'd1;
        if (w_term) begin
          r_data  <= bus.io;
          r_valid <= 1'b1;
          r_last  <= !r_burst || w_end;
          if (r_burst && !w_end) r_ptr <= r_ptr + 7'd1;
        end
      end
    end
  assign bus.valid = r_valid;
  assign bus.data  = r_data;
  assign bus.last  = r_last;
  assign bus.err   = r_err;
endmodule

// File: doc/sha256_const_rom.md
# sha256_const_rom

Synchronous fetch controller for the SHA-256 constant EEPROMs. It drives LANES byte-wide EEPROM chips in parallel on a shared address bus and waits a programmable number of access cycles. It assembles the lane bytes into one word and hands H (initial hash) or K (round) constants to the hash core over a request/valid handshake. Burst mode streams consecutive constants without re-requesting.

## Interface
- LANES, 4, byte lanes (chips) per word; DATA width = 8*LANES.
- ADDR_W, 13, EEPROM address width (8K x 8 devices).
- WAIT_CYCLES, 2, clock cycles the IO bus needs to settle after address/CE/OE (covers 150 ns access); legal range 1..15.
- H_BASE, 0, EEPROM address of H0.
- K_BASE, 8, EEPROM address of K0.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  1  fetch request; accepted on a rising edge where REQ=1 and READY=1.
- SEL  in  1  table select: 0 = H (8 entries), 1 = K (64 entries).
- IDX  in  7  start index within the selected table.
- BURST  in  1  1 = stream from IDX to the table's last entry; 0 = single word.
- READY  out  1  controller idle, REQ will be accepted.
- VALID  out  1  one-cycle strobe: DATA holds a fetched word.
- DATA  out  8*LANES  fetched word; lane 0 (first chip) is the most significant byte.
- LAST  out  1  qualifies VALID: final word of the transfer.
- ERR  out  1  one-cycle strobe: request rejected because the index is out of range.
- A  out  ADDR_W  EEPROM address, common to all lanes.
- CE_N  out  1  chip enable to all lanes, active-low.
- OE_N  out  1  output enable to all lanes, active-low. WE_N is tied high outside this block.
- IO  in  8*LANES  concatenated lane data, lane 0 in the most significant byte.

## Operation
- Reset values: READY=1, VALID=0, LAST=0, ERR=0, DATA=0, A=0, CE_N=1, OE_N=1, state IDLE.
- States:
  - IDLE:
    - REQ accepted with a legal index: latch SEL, BURST and ptr=IDX, then go to ACCESS.
    - REQ accepted with an illegal index (H: IDX>7; K: IDX>63): pulse ERR, stay in IDLE.
  - ACCESS:
    - Outputs: A = base+ptr, CE_N=0, OE_N=0, READY=0.
    - Wait counter runs from 0 to WAIT_CYCLES. On its terminal edge, register IO into DATA and pulse VALID.
    - Next state: if BURST=1 and ptr is not the last entry, increment ptr, clear the counter and stay in ACCESS. Otherwise go to IDLE.
- On the edge that returns the block to IDLE, CE_N and OE_N go to 1 and READY goes to 1.
- LAST=1 together with the final VALID: always for single fetches, and at index 7 (H) or 63 (K) in a burst.
- REQ is ignored while READY=0. SEL, IDX and BURST are sampled only at acceptance.
- The pointer is 7 bits wide. The address is base + ptr, truncated to ADDR_W bits. A burst never wraps past the table end.
- Asserting RST_N mid-transfer aborts immediately: CE_N and OE_N go to 1 and no VALID is produced.

## Timing
- Acceptance edge t: A, CE_N and OE_N are valid from t.
- First VALID is high in the cycle following edge t+WAIT_CYCLES+1. Latency = WAIT_CYCLES+1 cycles.
- Burst throughput: one word every WAIT_CYCLES+1 cycles. A moves to the next address on the same edge that captures the current word.
- READY rises on the edge of the final VALID. A new REQ can be accepted on the next edge, giving a single-cycle turnaround.
- ERR is high in the cycle after the rejecting edge. READY stays 1 throughout.

## Configuration
- CONST_ROM_SHA224_EN:
  - Defined:
    - Adds input H224 (1 bit), sampled at acceptance.
    - SEL=0 with H224=1 reads the SHA-224 IV at EEPROM addresses 72..79 (H_BASE+72). Range checking and LAST are the same as for the H table.
  - Undefined: the port does not exist and the H table is always the SHA-256 IV.

## Test plan
- Reset, then REQ with SEL=0, IDX=0, BURST=0, WAIT_CYCLES=2:
  - A=0 and CE_N=OE_N=0 from the acceptance edge.
  - VALID and LAST high 3 cycles later with DATA=32'h6a09e667; READY returns on the same edge.
- Single fetch with SEL=1, IDX=63 -> DATA=32'hc67178f2, LAST=1.
- Burst with SEL=0, IDX=5 -> three VALIDs spaced 3 cycles apart:
  - DATA = 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19.
  - LAST only on the third.
- REQ with SEL=1, IDX=64 -> ERR pulse, CE_N stays 1, no VALID. REQ with SEL=0, IDX=8 -> same result.
- RST_N low during the wait of a K burst -> CE_N and OE_N go to 1 immediately, no further VALID, READY=1 after release.
- With CONST_ROM_SHA224_EN defined, SEL=0, H224=1, IDX=0 -> A=72 and DATA = the word loaded at 72, 32'hc1059ed8.
